// File: rtl/tv80_alu16_seq.sv
// Two-cycle 16-bit ADD/ADC/SUB/SBC sequencer driving a shared 8-bit TV80 ALU.
// Low byte runs first, high byte second, with carry and zero chained through the ALU flags.
module tv80_alu16_seq #(
    parameter int unsigned Flag_C = 4,
    parameter int unsigned Flag_H = 5,
    parameter int unsigned Flag_N = 6,
    parameter int unsigned Flag_Z = 7
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [15:0] opa,
    input  logic [15:0] opb,
    input  logic [7:0]  flags_in,
    input  logic        abort,
    output logic        ready,
    output logic        done,
    output logic [15:0] result,
    output logic [7:0]  flags_out,
    output logic [3:0]  alu_op,
    output logic        alu_arith16,
    output logic        alu_z16,
    output logic [7:0]  alu_busa,
    output logic [7:0]  alu_busb,
    output logic [7:0]  alu_f_in,
    input  logic [7:0]  alu_q,
    input  logic [7:0]  alu_f_out
);

    typedef enum logic [1:0] {StIdle, StLo, StHi} state_e;

    localparam logic [7:0] FlagMask = (8'd1 << Flag_C) | (8'd1 << Flag_H) |
                                      (8'd1 << Flag_N) | (8'd1 << Flag_Z);

    state_e      state_q, state_d;
    logic [1:0]  op_q, op_d;
    logic [15:0] opa_q, opa_d;
    logic [15:0] opb_q, opb_d;
    logic [7:0]  flags_q, flags_d;
    logic [7:0]  res_lo_q, res_lo_d;
    logic [7:0]  fl_lo_q, fl_lo_d;
    logic [15:0] result_q, result_d;
    logic [7:0]  flags_out_q, flags_out_d;
    logic        done_q, done_d;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        flags_d     = flags_q;
        res_lo_d    = res_lo_q;
        fl_lo_d     = fl_lo_q;
        result_d    = result_q;
        flags_out_d = flags_out_q;
        done_d      = 1'b0;
        alu_op      = 4'b1111;
        alu_arith16 = 1'b0;
        alu_z16     = 1'b0;
        alu_busa    = 8'h00;
        alu_busb    = 8'h00;
        alu_f_in    = 8'h00;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d    = op;
                    opa_d   = opa;
                    opb_d   = opb;
                    flags_d = flags_in;
                    state_d = StLo;
                end
            end
            StLo: begin
                alu_op      = {2'b00, op_q};
                alu_arith16 = (op_q == 2'b00);
                alu_busa    = opa_q[7:0];
                alu_busb    = opb_q[7:0];
                alu_f_in    = flags_q;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    res_lo_d = alu_q;
                    fl_lo_d  = alu_f_out;
                    state_d  = StHi;
                end
            end
            StHi: begin
                // High byte always consumes the low-byte carry; Z16 ANDs in the low-byte zero.
                alu_op      = {2'b00, op_q[1], 1'b1};
                alu_arith16 = (op_q == 2'b00);
                alu_z16     = (op_q != 2'b00);
                alu_busa    = opa_q[15:8];
                alu_busb    = opb_q[15:8];
                alu_f_in    = fl_lo_q;
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    result_d    = {alu_q, res_lo_q};
                    flags_out_d = alu_f_out & FlagMask;
                    done_d      = 1'b1;
                    state_d     = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            op_q        <= 2'b00;
            opa_q       <= 16'h0000;
            opb_q       <= 16'h0000;
            flags_q     <= 8'h00;
            res_lo_q    <= 8'h00;
            fl_lo_q     <= 8'h00;
            result_q    <= 16'h0000;
            flags_out_q <= 8'h00;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            flags_q     <= flags_d;
            res_lo_q    <= res_lo_d;
            fl_lo_q     <= fl_lo_d;
            result_q    <= result_d;
            flags_out_q <= flags_out_d;
            done_q      <= done_d;
        end
    end

    assign ready     = (state_q == StIdle);
    assign done      = done_q;
    assign result    = result_q;
    assign flags_out = flags_out_q;

endmodule

// File: tb/tb_tv80_alu16_seq.sv
// Bench for tv80_alu16_seq: an 8-bit ALU stand-in closes the loop, and a scoreboard checks
// every done pulse against a whole-word reference model.
module tb_tv80_alu16_seq;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic [15:0] opa;
    logic [15:0] opb;
    logic [7:0]  flags_in;
    logic        abort;
    logic        ready;
    logic        done;
    logic [15:0] result;
    logic [7:0]  flags_out;
    logic [3:0]  alu_op;
    logic        alu_arith16;
    logic        alu_z16;
    logic [7:0]  alu_busa;
    logic [7:0]  alu_busb;
    logic [7:0]  alu_f_in;
    logic [7:0]  alu_q;
    logic [7:0]  alu_f_out;

    int total = 0;
    int bad   = 0;
    logic [23:0] sb_q[$];
    logic [15:0] last_res = 16'h0000;
    logic [7:0]  last_fl  = 8'h00;

    tv80_alu16_seq dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .op          (op),
        .opa         (opa),
        .opb         (opb),
        .flags_in    (flags_in),
        .abort       (abort),
        .ready       (ready),
        .done        (done),
        .result      (result),
        .flags_out   (flags_out),
        .alu_op      (alu_op),
        .alu_arith16 (alu_arith16),
        .alu_z16     (alu_z16),
        .alu_busa    (alu_busa),
        .alu_busb    (alu_busb),
        .alu_f_in    (alu_f_in),
        .alu_q       (alu_q),
        .alu_f_out   (alu_f_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 8-bit ALU stand-in (Mode 3 flag byte); low nibble of F_Out is junk so masking is exercised.
    always_comb begin
        logic [8:0] full;
        logic [4:0] half;
        logic       cin;
        logic       z;
        alu_q     = 8'h00;
        alu_f_out = 8'h00;
        full      = 9'h000;
        half      = 5'h00;
        cin       = alu_op[0] & alu_f_in[4];
        z         = 1'b0;
        if (alu_op[3:2] == 2'b00) begin
            if (alu_op[1]) begin
                full = {1'b0, alu_busa} - {1'b0, alu_busb} - {8'h00, cin};
                half = {1'b0, alu_busa[3:0]} - {1'b0, alu_busb[3:0]} - {4'h0, cin};
            end else begin
                full = {1'b0, alu_busa} + {1'b0, alu_busb} + {8'h00, cin};
                half = {1'b0, alu_busa[3:0]} + {1'b0, alu_busb[3:0]} + {4'h0, cin};
            end
            alu_q = full[7:0];
            if (alu_arith16)  z = alu_f_in[7];
            else if (alu_z16) z = (full[7:0] == 8'h00) && alu_f_in[7];
            else              z = (full[7:0] == 8'h00);
            alu_f_out = {z, alu_op[1], half[4], full[8], 4'b1010};
        end
    end

    // Whole-word reference: returns {result, flags}.
    function automatic logic [23:0] model(input logic [1:0] o, input logic [15:0] a,
                                          input logic [15:0] b, input logic [7:0] f);
        int          cin;
        int          r;
        logic        h;
        logic        c;
        logic        z;
        logic [15:0] res;
        cin = (o[0]) ? int'(f[4]) : 0;
        if (o[1]) begin
            r = int'(a) - int'(b) - cin;
            h = int'(a & 16'h0fff) < int'(b & 16'h0fff) + cin;
            c = int'(a) < int'(b) + cin;
        end else begin
            r = int'(a) + int'(b) + cin;
            h = (int'(a & 16'h0fff) + int'(b & 16'h0fff) + cin) > 32'h0fff;
            c = r > 32'hffff;
        end
        res = r[15:0];
        z = (o == 2'b00) ? f[7] : (res == 16'h0000);
        return {res, z, o[1], h, c, 4'b0000};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n && done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                logic [23:0] e;
                e = sb_q.pop_front();
                check("result", 32'(result), 32'(e[23:8]));
                check("flags_out", 32'(flags_out), 32'(e[7:0]));
                last_res = e[23:8];
                last_fl  = e[7:0];
            end
        end
    end

    // Caller sits on a negedge; returns on the negedge after the accepting edge.
    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] f);
        start    = 1'b1;
        op       = o;
        opa      = a;
        opb      = b;
        flags_in = f;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] f, input logic [23:0] exp, input bit poke);
        sb_q.push_back(exp);
        issue(o, a, b, f);
        check("ready_low_busy", 32'(ready), 32'h0);
        check("done_early_lo", 32'(done), 32'h0);
        if (poke) begin
            start    = 1'b1;
            op       = ~o;
            opa      = ~a;
            opb      = a;
            flags_in = ~f;
        end
        @(negedge clk);
        start = 1'b0;
        check("done_early_hi", 32'(done), 32'h0);
        @(negedge clk);
        check("done_pulse", 32'(done), 32'h1);
        check("ready_with_done", 32'(ready), 32'h1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [15:0] ra;
        logic [15:0] rb;
        logic [7:0]  rf;
        reset_n  = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        opa      = 16'h0000;
        opb      = 16'h0000;
        flags_in = 8'h00;
        abort    = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 32'(ready), 32'h1);
        check("rst_done", 32'(done), 32'h0);
        check("rst_result", 32'(result), 32'h0);
        check("rst_flags", 32'(flags_out), 32'h0);
        check("rst_alu_op", 32'(alu_op), 32'hf);
        reset_n = 1'b1;
        @(negedge clk);

        run_op(2'b00, 16'h8A23, 16'h0605, 8'h80, {16'h9028, 8'hA0}, 1'b0);
        run_op(2'b01, 16'hFFFF, 16'h0000, 8'h10, {16'h0000, 8'hB0}, 1'b0);
        run_op(2'b11, 16'h0000, 16'h0001, 8'h00, {16'hFFFF, 8'h70}, 1'b0);
        run_op(2'b10, 16'h1200, 16'h0200, 8'h00, {16'h1000, 8'h40}, 1'b0);
        // Started in the done cycle of the previous op; start while busy is ignored.
        run_op(2'b00, 16'h1234, 16'h4321, 8'h00, {16'h5555, 8'h00}, 1'b1);
        @(negedge clk);
        check("no_second_done", 32'(done), 32'h0);

        // Abort in HI.
        issue(2'b00, 16'hFFFF, 16'hFFFF, 8'h00);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_hi_done", 32'(done), 32'h0);
        check("abort_hi_ready", 32'(ready), 32'h1);
        check("abort_hi_result", 32'(result), 32'(last_res));
        check("abort_hi_flags", 32'(flags_out), 32'(last_fl));
        @(negedge clk);
        check("abort_hi_no_late_done", 32'(done), 32'h0);

        // Abort in LO.
        issue(2'b10, 16'h0001, 16'h0002, 8'h00);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_lo_ready", 32'(ready), 32'h1);
        check("abort_lo_done", 32'(done), 32'h0);
        @(negedge clk);
        check("abort_lo_no_late_done", 32'(done), 32'h0);
        check("abort_lo_result", 32'(result), 32'(last_res));

        // Reset mid-LO.
        issue(2'b01, 16'h7777, 16'h1111, 8'h10);
        reset_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'h1);
        check("midrst_done", 32'(done), 32'h0);
        check("midrst_result", 32'(result), 32'h0);
        check("midrst_flags", 32'(flags_out), 32'h0);
        check("midrst_alu_op", 32'(alu_op), 32'hf);
        last_res = 16'h0000;
        last_fl  = 8'h00;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 60; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = 16'($urandom);
            rb = 16'($urandom);
            rf = 8'($urandom);
            if (i % 8 == 0) rb = ra;
            if (i % 8 == 1) begin
                ra = 16'hFFFF;
                rb = 16'($urandom_range(0, 1));
            end
            run_op(ro, ra, rb, rf, model(ro, ra, rb, rf), (i % 5) == 0);
        end

        @(negedge clk);
        check("final_done_low", 32'(done), 32'h0);
        @(negedge clk);
        check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
